// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl -- multicycle sequencing controller for the MIPS core.
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with
// instruction and data memory, and decodes the IR into the datapath controls.
// It traps on illegal opcodes/functs (err=01) or on a memory ack timeout (err=10).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   instr, zero              IR contents and ALU zero flag from the datapath
//   imem_req/imem_ack        instruction fetch handshake
//   dmem_req/dmem_we/ack     data access handshake (we=1 for sw)
//   irwrite, pcwrite, pcsrc  IR/PC load controls (pcsrc 00 +4, 01 branch, 10 jump)
//   regwrite, regdst, alusrc, memtoreg, aluop   datapath controls
//   state, err, instr_done   debug state, sticky error code, retire pulse
//   cyc_cnt, ret_cnt         performance counters
//
// Build option: define MCTRL_PERF_EN to enable the performance counters.
// Without it, both counter ports are tied to 0.
module mips_mc_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        irwrite,
  output logic        pcwrite,
  output logic [1:0]  pcsrc,
  output logic        regwrite,
  output logic        regdst,
  output logic        alusrc,
  output logic        memtoreg,
  output logic [2:0]  aluop,
  output logic [2:0]  state,
  output logic [1:0]  err,
  output logic        instr_done,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd7;

  logic [2:0] st, st_nx;
  logic [1:0] err_q, err_nx;
  logic [7:0] wcnt;
  logic       run;

  // IR decode
  logic [5:0] op, fn;
  logic       is_rt, r_ok, is_addi, is_lw, is_sw, is_beq, is_j, legal, wait_to;
  logic [2:0] r_aluop;
  logic       unused_instr;

  assign op           = instr[31:26];
  assign fn           = instr[5:0];
  assign unused_instr = ^instr[25:6];
  assign is_rt        = (op == 6'h00);
  assign is_addi      = (op == 6'h08);
  assign is_lw        = (op == 6'h23);
  assign is_sw        = (op == 6'h2b);
  assign is_beq       = (op == 6'h04);
  assign is_j         = (op == 6'h02);

  always_comb begin
    r_ok    = 1'b1;
    r_aluop = 3'b010;
    case (fn)
      6'h20:   r_aluop = 3'b010;
      6'h22:   r_aluop = 3'b110;
      6'h24:   r_aluop = 3'b000;
      6'h25:   r_aluop = 3'b001;
      6'h2a:   r_aluop = 3'b111;
      default: r_ok    = 1'b0;
    endcase
    r_ok = r_ok & is_rt;
  end

  assign legal   = r_ok | is_addi | is_lw | is_sw | is_beq | is_j;
  // wcnt holds (wait cycles so far - 1), so this is the TIMEOUT-th cycle
  // without ack; an ack in that same cycle still wins.
  assign wait_to = (wcnt == 8'(TIMEOUT - 1));

  always_comb begin
    st_nx  = st;
    err_nx = err_q;
    case (st)
      S_IDLE:   if (run) st_nx = S_FETCH;
      S_FETCH:  if (imem_ack) st_nx = S_DECODE;
                else if (wait_to) begin st_nx = S_TRAP; err_nx = 2'b10; end
      S_DECODE: if (legal) st_nx = S_EXEC;
                else begin st_nx = S_TRAP; err_nx = 2'b01; end
      S_EXEC:   if (r_ok | is_addi) st_nx = S_WB;
                else if (is_lw | is_sw) st_nx = S_MEM;
                else st_nx = S_FETCH;
      S_MEM:    if (dmem_ack) st_nx = is_sw ? S_FETCH : S_WB;
                else if (wait_to) begin st_nx = S_TRAP; err_nx = 2'b10; end
      S_WB:     st_nx = S_FETCH;
      S_TRAP:   st_nx = S_TRAP;
      default:  st_nx = S_IDLE;
    endcase
  end

  // run delays the first IDLE->FETCH by one edge, so the first fetch request
  // appears on the second rising edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= S_IDLE;
      err_q <= 2'b00;
      wcnt  <= '0;
      run   <= 1'b0;
    end else begin
      st    <= st_nx;
      err_q <= err_nx;
      run   <= 1'b1;
      if (st_nx != st)                      wcnt <= '0;
      else if (st == S_FETCH || st == S_MEM) wcnt <= wcnt + 8'd1;
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = 2'b00;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    alusrc     = 1'b0;
    memtoreg   = 1'b0;
    aluop      = 3'b010;
    instr_done = 1'b0;
    if (!rst) aluop = 3'b000;   // everything reads 0 while reset is held
    else begin
      case (st)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin irwrite = 1'b1; pcwrite = 1'b1; end
        end
        S_EXEC: begin
          if (r_ok)        aluop = r_aluop;
          else if (is_beq) aluop = 3'b110;
          alusrc = is_addi | is_lw | is_sw;
          if (is_beq) begin pcwrite = zero; pcsrc = 2'b01; instr_done = 1'b1; end
          if (is_j)   begin pcwrite = 1'b1; pcsrc = 2'b10; instr_done = 1'b1; end
        end
        S_MEM: begin
          dmem_req   = 1'b1;
          dmem_we    = is_sw;
          instr_done = dmem_ack & is_sw;
        end
        S_WB: begin
          regwrite   = 1'b1;
          regdst     = r_ok;
          memtoreg   = is_lw;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = st;
  assign err   = err_q;

`ifdef MCTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (st != S_IDLE && st != S_TRAP) cyc_cnt <= cyc_cnt + 32'd1;
      if (instr_done)                   ret_cnt <= ret_cnt + 32'd1;
    end
  end
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule
